// File: rtl/display_scan_scheduler_if.sv
// Bus bundle for the seven-segment scan scheduler: scan controls, digit
// patterns in, anode/segment drive and frame marker out.
interface display_scan_scheduler_if;
    logic        Enable;
    logic [7:0]  DigitMask;
    logic [7:0]  BlinkMask;
    logic [3:0]  Brightness;
    logic [63:0] SegIn;
    logic [7:0]  AN;
    logic [7:0]  BCD;
    logic        FrameStart;

    modport master (
        output Enable, DigitMask, BlinkMask, Brightness, SegIn,
        input  AN, BCD, FrameStart
    );

    modport slave (
        input  Enable, DigitMask, BlinkMask, Brightness, SegIn,
        output AN, BCD, FrameStart
    );
endinterface

// File: rtl/display_scan_scheduler.sv
// BLANK/ON scan sequencer for the 8-digit alarm clock display.
// Define SCAN_BLINK_EN to build the frame-counted set-mode blink.
module display_scan_scheduler #(
    parameter int DWELL_CYCLES = 62500,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 100
) (
    input logic                     Clock,
    input logic                     resetSW,
    display_scan_scheduler_if.slave bus
);
    localparam int OW   = $clog2(DWELL_CYCLES) + 5;
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam int KW   = (OW > CW) ? OW : CW;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, ON} state_t;

    state_t        state, state_n;
    logic [2:0]    Idx, idx_n, nxt_idx, low_idx, base, cand;
    logic [CW-1:0] Cnt, cnt_n;
    logic          first, first_n, found;
    logic [7:0]    pat, pat_n, an_n, bcd_n;
    logic          fs_n, gate_n;
    logic [KW-1:0] on_limit;

    // Full-precision product before the >>4 so low brightness never rounds to 0
    assign on_limit = KW'(((OW'(bus.Brightness) + OW'(1)) * OW'(DWELL_CYCLES)) >> 4);

    // Next enabled digit (from 0 on the first slot, else after Idx) and frame-leading digit
    always_comb begin
        base    = first ? 3'd0 : Idx + 3'd1;
        cand    = '0;
        nxt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = base + 3'(k);
            if (!found && bus.DigitMask[cand]) begin
                nxt_idx = cand;
                found   = 1'b1;
            end
        end
        low_idx = '0;
        for (int i = 7; i >= 0; i--)
            if (bus.DigitMask[i]) low_idx = 3'(i);
    end

    always_comb begin
        state_n = state;
        idx_n   = Idx;
        cnt_n   = Cnt;
        first_n = first;
        pat_n   = pat;
        fs_n    = 1'b0;
        if (!bus.Enable) begin
            state_n = BLANK;
            cnt_n   = '0;
            first_n = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (Cnt == BLANK_LAST) begin
                        cnt_n = '0;
                        if (found) begin
                            state_n = ON;
                            idx_n   = nxt_idx;
                            first_n = 1'b0;
                            pat_n   = bus.SegIn[{nxt_idx, 3'b000} +: 8];
                            fs_n    = (nxt_idx == low_idx);
                        end
                    end else begin
                        cnt_n = Cnt + CW'(1);
                    end
                end
                ON: begin
                    if (Cnt == DWELL_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = Cnt + CW'(1);
                    end
                end
                default: state_n = BLANK;
            endcase
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [BW-1:0] BlinkCnt;
    logic          BlinkPhase, phase_n;

    // Phase flips on the frame-start edge so every slot of a frame shares one phase
    assign phase_n = (fs_n && BlinkCnt == BW'(BLINK_FRAMES)) ? ~BlinkPhase : BlinkPhase;
    assign gate_n  = phase_n & bus.BlinkMask[idx_n];

    always_ff @(posedge Clock or posedge resetSW) begin
        if (resetSW) begin
            BlinkCnt   <= '0;
            BlinkPhase <= 1'b0;
        end else if (fs_n) begin
            BlinkCnt   <= (BlinkCnt == BW'(BLINK_FRAMES)) ? BW'(1) : BlinkCnt + BW'(1);
            BlinkPhase <= phase_n;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^bus.BlinkMask;
    assign gate_n       = 1'b0;
`endif

    always_comb begin
        an_n  = 8'hFF;
        bcd_n = 8'hFF;
        if (state_n == ON && KW'(cnt_n) < on_limit && !gate_n) begin
            an_n  = ~(8'h01 << idx_n);
            bcd_n = pat_n;
        end
    end

    always_ff @(posedge Clock or posedge resetSW) begin
        if (resetSW) begin
            state          <= BLANK;
            Idx            <= '0;
            Cnt            <= '0;
            first          <= 1'b1;
            pat            <= 8'hFF;
            bus.AN         <= 8'hFF;
            bus.BCD        <= 8'hFF;
            bus.FrameStart <= 1'b0;
        end else begin
            state          <= state_n;
            Idx            <= idx_n;
            Cnt            <= cnt_n;
            first          <= first_n;
            pat            <= pat_n;
            bus.AN         <= an_n;
            bus.BCD        <= bcd_n;
            bus.FrameStart <= fs_n;
        end
    end
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Randomized and directed bench for display_scan_scheduler against a
// slot-schedule model (expected AN/BCD/FrameStart trace per cycle).
module tb_display_scan_scheduler;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int BF    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_scheduler_if bus();

    display_scan_scheduler #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(BF)
    ) dut (
        .Clock(clk),
        .resetSW(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_an[$];
    logic [7:0] exp_bcd[$];
    logic       exp_fs[$];

    logic [7:0] t_mask  [4] = '{8'hFF, 8'h05, 8'hFF, 8'hFF};
    logic [3:0] t_bright[4] = '{4'd15, 4'd15, 4'd3, 4'd15};
    logic [7:0] t_blink [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
    int         t_ncyc  [4] = '{300, 120, 300, 1300};

    // Expected trace from reset release: frames of enabled digits in ascending
    // order, each slot = BLANK dark cycles then DWELL cycles with the first
    // (b+1)*DWELL/16 lit, blinked digits dark in odd BF-frame groups.
    task automatic build_trace(input logic [7:0] mask, input logic [3:0] bright,
                               input logic [7:0] blink, input logic [63:0] segs, input int n);
        int onlen, f;
        bit lead, dark, lit;
        logic [7:0] onehot;
        exp_an.delete(); exp_bcd.delete(); exp_fs.delete();
        onlen = ((int'(bright) + 1) * DWELL) / 16;
        f = 1;
        while (exp_an.size() < n) begin
            lead = 1'b1;
            for (int d = 0; d < 8; d++) begin
                if (mask[d]) begin
                    for (int j = 0; j < BLANK; j++) begin
                        exp_an.push_back(8'hFF); exp_bcd.push_back(8'hFF); exp_fs.push_back(1'b0);
                    end
                    dark = 1'b0;
`ifdef SCAN_BLINK_EN
                    dark = blink[d] && ((((f - 1) / BF) % 2) == 1);
`endif
                    onehot = 8'h01 << d;
                    for (int j = 0; j < DWELL; j++) begin
                        lit = (j < onlen) && !dark;
                        exp_an.push_back(lit ? ~onehot : 8'hFF);
                        exp_bcd.push_back(lit ? segs[8*d +: 8] : 8'hFF);
                        exp_fs.push_back(j == 0 && lead);
                    end
                    lead = 1'b0;
                end
            end
            f++;
        end
    endtask

    task automatic apply_reset(input logic [7:0] mask, input logic [3:0] bright,
                               input logic [7:0] blink, input logic [63:0] segs);
        @(negedge clk);
        rst            = 1'b1;
        bus.Enable     = 1'b1;
        bus.DigitMask  = mask;
        bus.Brightness = bright;
        bus.BlinkMask  = blink;
        bus.SegIn      = segs;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.Enable     = 1'b1;
        bus.DigitMask  = 8'hFF;
        bus.BlinkMask  = 8'h00;
        bus.Brightness = 4'd15;
        bus.SegIn      = 64'h0123_4567_89AB_CDEF;
        #22;
        checks++;
        if (bus.AN !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", bus.AN); end
        checks++;
        if (bus.BCD !== 8'hFF) begin errors++; $display("FAIL reset_bcd: got %h want ff", bus.BCD); end
        checks++;
        if (bus.FrameStart !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", bus.FrameStart); end
    endtask

    task automatic test_directed_scans();
        logic [63:0] segs;
        for (int t = 0; t < 4; t++) begin
            segs = {$urandom, $urandom};
            build_trace(t_mask[t], t_bright[t], t_blink[t], segs, t_ncyc[t]);
            apply_reset(t_mask[t], t_bright[t], t_blink[t], segs);
            for (int k = 0; k < t_ncyc[t]; k++) begin
                checks++;
                if (bus.AN !== exp_an[k] || bus.BCD !== exp_bcd[k] || bus.FrameStart !== exp_fs[k]) begin
                    errors++;
                    $display("FAIL directed%0d cyc %0d: AN=%h BCD=%h FS=%b want AN=%h BCD=%h FS=%b",
                             t, k, bus.AN, bus.BCD, bus.FrameStart, exp_an[k], exp_bcd[k], exp_fs[k]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random_scans();
        logic [7:0]  mask, blink;
        logic [3:0]  bright;
        logic [63:0] segs;
        for (int t = 0; t < 8; t++) begin
            mask   = 8'($urandom_range(1, 255));
            bright = 4'($urandom);
            blink  = 8'($urandom);
            segs   = {$urandom, $urandom};
            build_trace(mask, bright, blink, segs, 720);
            apply_reset(mask, bright, blink, segs);
            for (int k = 0; k < 720; k++) begin
                checks++;
                if (bus.AN !== exp_an[k] || bus.BCD !== exp_bcd[k] || bus.FrameStart !== exp_fs[k]) begin
                    errors++;
                    $display("FAIL random%0d mask=%h br=%0d cyc %0d: AN=%h BCD=%h FS=%b want AN=%h BCD=%h FS=%b",
                             t, mask, bright, k, bus.AN, bus.BCD, bus.FrameStart, exp_an[k], exp_bcd[k], exp_fs[k]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_segin_latch();
        logic [63:0] segs;
        logic [7:0]  old_b, new_b, want;
        segs  = {$urandom, $urandom};
        old_b = segs[7:0];
        new_b = ~old_b;
        apply_reset(8'h01, 4'd15, 8'h00, segs);
        for (int k = 0; k < 23; k++) begin
            want = (k < 2) ? 8'hFF : (k < 18) ? old_b : (k < 20) ? 8'hFF : new_b;
            checks++;
            if (bus.BCD !== want) begin
                errors++;
                $display("FAIL segin_latch cyc %0d: BCD=%h want %h", k, bus.BCD, want);
            end
            if (k == 7) bus.SegIn[7:0] = new_b;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_mask();
        apply_reset(8'h00, 4'd15, 8'h00, {$urandom, $urandom});
        for (int k = 0; k < 200; k++) begin
            checks++;
            if (bus.AN !== 8'hFF || bus.BCD !== 8'hFF || bus.FrameStart !== 1'b0) begin
                errors++;
                $display("FAIL zero_mask cyc %0d: AN=%h BCD=%h FS=%b want ff ff 0", k, bus.AN, bus.BCD, bus.FrameStart);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_on();
        logic [63:0] segs;
        segs = {$urandom, $urandom};
        apply_reset(8'h0C, 4'd15, 8'h00, segs);
        repeat (8) @(negedge clk);
        checks++;
        if (bus.AN !== 8'hFB) begin errors++; $display("FAIL mid_on_pre: AN=%h want fb", bus.AN); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.AN !== 8'hFF || bus.BCD !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset: AN=%h BCD=%h want ff ff", bus.AN, bus.BCD);
        end
        build_trace(8'h0C, 4'd15, 8'h00, segs, 80);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            checks++;
            if (bus.AN !== exp_an[k] || bus.BCD !== exp_bcd[k] || bus.FrameStart !== exp_fs[k]) begin
                errors++;
                $display("FAIL restart cyc %0d: AN=%h BCD=%h FS=%b want AN=%h BCD=%h FS=%b",
                         k, bus.AN, bus.BCD, bus.FrameStart, exp_an[k], exp_bcd[k], exp_fs[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_toggle();
        logic [63:0] segs;
        segs = {$urandom, $urandom};
        apply_reset(8'h3A, 4'd15, 8'h00, segs);
        repeat (30) @(negedge clk);
        bus.Enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.AN !== 8'hFF || bus.BCD !== 8'hFF || bus.FrameStart !== 1'b0) begin
                errors++;
                $display("FAIL disabled cyc %0d: AN=%h BCD=%h FS=%b want ff ff 0", k, bus.AN, bus.BCD, bus.FrameStart);
            end
        end
        build_trace(8'h3A, 4'd15, 8'h00, segs, 200);
        bus.Enable = 1'b1;
        for (int k = 0; k < 200; k++) begin
            checks++;
            if (bus.AN !== exp_an[k] || bus.BCD !== exp_bcd[k] || bus.FrameStart !== exp_fs[k]) begin
                errors++;
                $display("FAIL reenable cyc %0d: AN=%h BCD=%h FS=%b want AN=%h BCD=%h FS=%b",
                         k, bus.AN, bus.BCD, bus.FrameStart, exp_an[k], exp_bcd[k], exp_fs[k]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed_scans();
        test_segin_latch();
        test_zero_mask();
        test_reset_mid_on();
        test_enable_toggle();
        test_random_scans();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
